// File: rtl/stress_monitor_mc.sv
// Multi-channel pulse-rate stress monitor: counts synchronized rising edges per channel over a
// fixed window, grades each channel with hysteresis and raises an alarm on sustained HIGH stress.

module stress_monitor_ch #(
    parameter int CNT_W         = 8,
    parameter int TH_MED        = 16,
    parameter int TH_HIGH       = 32,
    parameter int HYST          = 2,
    parameter int ALARM_WINDOWS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pulse_i,
    input  logic             term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [1:0]       level_o,
    output logic             hit_o
);
    typedef enum logic [1:0] {LVL_LOW = 2'b00, LVL_MED = 2'b01, LVL_HIGH = 2'b10} lvl_e;

    localparam int              CW         = $clog2(ALARM_WINDOWS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] T_MED     = CNT_W'(TH_MED);
    localparam logic [CNT_W-1:0] T_HIGH    = CNT_W'(TH_HIGH);
    localparam logic [CNT_W-1:0] T_MED_DN  = CNT_W'(TH_MED - HYST);
    localparam logic [CNT_W-1:0] T_HIGH_DN = CNT_W'(TH_HIGH - HYST);
    localparam logic [CW-1:0]    CONS_MAX  = CW'(ALARM_WINDOWS);

    logic             s1_q, s2_q, s3_q, edge_w;
    logic [CNT_W-1:0] live_q, latched_q, sum_w;
    lvl_e             lvl_q, lvl_d;
    logic [CW-1:0]    consec_q, consec_d;

    assign edge_w = s2_q & ~s3_q;
    // Saturating live count including this cycle's edge; in the terminal cycle this is the window total.
    assign sum_w  = (edge_w && live_q != CNT_MAX) ? live_q + 1'b1 : live_q;

    always_comb begin
        lvl_d = lvl_q;
        case (lvl_q)
            LVL_LOW: begin
                if (sum_w >= T_HIGH)     lvl_d = LVL_HIGH;
                else if (sum_w >= T_MED) lvl_d = LVL_MED;
            end
            LVL_MED: begin
                if (sum_w >= T_HIGH)        lvl_d = LVL_HIGH;
                else if (sum_w < T_MED_DN)  lvl_d = LVL_LOW;
            end
            LVL_HIGH: begin
                if (sum_w < T_MED_DN)       lvl_d = LVL_LOW;
                else if (sum_w < T_HIGH_DN) lvl_d = LVL_MED;
            end
            default: lvl_d = LVL_LOW;
        endcase
        consec_d = '0;
        if (lvl_d == LVL_HIGH)
            consec_d = (consec_q == CONS_MAX) ? consec_q : consec_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            live_q    <= '0;
            latched_q <= '0;
            lvl_q     <= LVL_LOW;
            consec_q  <= '0;
        end else begin
            // Synchronizer keeps sampling while disabled so re-enabling never fires a stale edge.
            s1_q <= pulse_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (ena) begin
                if (term_i) begin
                    latched_q <= sum_w;
                    live_q    <= '0;
                    lvl_q     <= lvl_d;
                    consec_q  <= consec_d;
                end else begin
                    live_q <= sum_w;
                end
            end
        end
    end

    assign cnt_o   = latched_q;
    assign level_o = lvl_q;
    assign hit_o   = (consec_d == CONS_MAX);
endmodule

module stress_monitor_mc #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 8,
    parameter int WINDOW_CYCLES = 1000,
    parameter int TH_MED        = 16,
    parameter int TH_HIGH       = 32,
    parameter int HYST          = 2,
    parameter int ALARM_WINDOWS = 3,
    localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NUM_CH-1:0]     pulse_in,
    input  logic [SEL_W-1:0]      sel_ch,
    output logic [CNT_W-1:0]      count_out,
    output logic [2*NUM_CH-1:0]   level_out,
    output logic                  alarm,
    output logic                  window_done
);
    localparam int WW = $clog2(WINDOW_CYCLES);

    logic [WW-1:0]    win_q, win_d;
    logic             term_w;
    logic             alarm_q, done_q;
    logic [CNT_W-1:0] cnt_w [NUM_CH];
    logic [NUM_CH-1:0] hit_w;

    assign term_w = (win_q == WW'(WINDOW_CYCLES - 1));
    assign win_d  = term_w ? '0 : win_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= '0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            win_q  <= win_d;
            done_q <= term_w;
            if (term_w) alarm_q <= |hit_w;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stress_monitor_ch #(
            .CNT_W(CNT_W), .TH_MED(TH_MED), .TH_HIGH(TH_HIGH),
            .HYST(HYST), .ALARM_WINDOWS(ALARM_WINDOWS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .pulse_i (pulse_in[i]),
            .term_i  (term_w),
            .cnt_o   (cnt_w[i]),
            .level_o (level_out[2*i +: 2]),
            .hit_o   (hit_w[i])
        );
    end

    always_comb begin
        count_out = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sel_ch == SEL_W'(i)) count_out = cnt_w[i];
    end

    assign alarm       = alarm_q;
    assign window_done = done_q;
endmodule

// File: tb/tb_stress_monitor_mc.sv
// Scoreboard bench for stress_monitor_mc: per-window expectations are queued as pulses are
// driven and checked on each window_done; a long-window instance covers counter saturation.

module tb_stress_monitor_mc;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [3:0] pulse_in;
    logic [1:0] sel_ch;
    logic [7:0] count_out, level_out;
    logic       alarm, window_done;

    logic       sat_rst_n, sat_pulse, sat_alarm, sat_wd;
    logic [7:0] sat_cnt, sat_lvl;
    logic       sat_finished = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0][7:0] cnt;
        logic [7:0]      lvl;
        logic            alm;
    } exp_t;
    exp_t sb_q[$];

    int m_lvl [4];
    int m_cons[4];

    always #5 clk = ~clk;

    stress_monitor_mc #(.WINDOW_CYCLES(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pulse_in(pulse_in), .sel_ch(sel_ch),
        .count_out(count_out), .level_out(level_out), .alarm(alarm), .window_done(window_done)
    );

    stress_monitor_mc #(.WINDOW_CYCLES(1000)) u_sat (
        .clk(clk), .rst_n(sat_rst_n), .ena(1'b1), .pulse_in({3'b000, sat_pulse}), .sel_ch(2'd0),
        .count_out(sat_cnt), .level_out(sat_lvl), .alarm(sat_alarm), .window_done(sat_wd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_lvl[k]  = 0;
            m_cons[k] = 0;
        end
    endtask

    // One full window of stimulus; gap>0 drops ena for that many cycles at window cycle 50,
    // tail adds a ch0 pulse whose edge lands in the terminal cycle.
    task automatic run_window(input int n0, input int n1, input int n2, input int n3,
                              input bit tail, input int gap);
        int   n[4];
        int   c;
        exp_t e;
        n     = '{n0, n1, n2, n3};
        e     = '0;
        for (int k = 0; k < 4; k++) begin
            c = n[k] + ((tail && k == 0) ? 1 : 0);
            if (c > 255) c = 255;
            e.cnt[k] = 8'(c);
            case (m_lvl[k])
                0:       m_lvl[k] = (c >= 32) ? 2 : (c >= 16) ? 1 : 0;
                1:       m_lvl[k] = (c >= 32) ? 2 : (c < 14) ? 0 : 1;
                default: m_lvl[k] = (c < 14) ? 0 : (c < 30) ? 1 : 2;
            endcase
            m_cons[k] = (m_lvl[k] == 2) ? ((m_cons[k] < 3) ? m_cons[k] + 1 : 3) : 0;
            e.lvl[2*k +: 2] = 2'(m_lvl[k]);
            if (m_cons[k] == 3) e.alm = 1'b1;
        end
        sb_q.push_back(e);
        for (int cy = 0; cy < 100; cy++) begin
            if (gap > 0 && cy == 50) begin
                ena = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    pulse_in = {3'b000, (g % 2 == 0) && (g < 40)};
                    tick();
                end
                ena = 1'b1;
            end
            for (int k = 0; k < 4; k++) pulse_in[k] = (cy % 2 == 0) && (cy < 2 * n[k]);
            if (tail && cy == 97) pulse_in[0] = 1'b1;
            if (cy == 99) chk("wd_early", window_done, 1'b0);
            tick();
        end
        pulse_in = '0;
        chk("wd_strobe", window_done, 1'b1);
    endtask

    // Scoreboard consumer: every window_done must match the oldest queued expectation.
    initial begin
        exp_t e;
        sel_ch = 2'd0;
        forever begin
            @(negedge clk);
            if (window_done) begin
                if (sb_q.size() == 0) begin
                    chk("wd_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("level", level_out, e.lvl);
                    chk("alarm", alarm, e.alm);
                    for (int i = 0; i < 4; i++) begin
                        sel_ch = 2'(i);
                        #1;
                        chk($sformatf("count%0d", i), count_out, e.cnt[i]);
                    end
                end
            end
        end
    end

    // Saturation on a 1000-cycle window: 300 edges must latch as 255.
    initial begin
        sat_rst_n = 1'b0;
        sat_pulse = 1'b0;
        repeat (3) tick();
        sat_rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            sat_pulse = (c % 2 == 0);
            tick();
        end
        sat_pulse = 1'b0;
        for (int t = 0; t < 1000 && !sat_wd; t++) tick();
        chk("sat_wd", sat_wd, 1'b1);
        chk("sat_count", sat_cnt, 8'd255);
        chk("sat_level", sat_lvl, 8'h02);
        chk("sat_alarm", sat_alarm, 1'b0);
        sat_finished = 1'b1;
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        pulse_in = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_level", level_out, 8'h00);
        chk("rst_alarm", alarm, 1'b0);
        chk("rst_wd", window_done, 1'b0);
        chk("rst_count", count_out, 8'h00);
        rst_n = 1'b1;

        run_window(0, 0, 0, 0, 1'b0, 0);
        run_window(20, 0, 35, 40, 1'b0, 0);
        run_window(0, 0, 31, 40, 1'b0, 0);
        run_window(0, 0, 29, 40, 1'b0, 0);
        run_window(0, 0, 13, 10, 1'b0, 0);
        run_window(20, 5, 0, 0, 1'b1, 50);
        run_window(0, 16, 0, 40, 1'b0, 0);
        run_window(0, 16, 0, 40, 1'b0, 0);
        run_window(0, 16, 0, 40, 1'b0, 0);

        // Partial window with ch0 at 15, then a one-cycle reset mid-window.
        for (int cy = 0; cy < 50; cy++) begin
            pulse_in[0] = (cy % 2 == 0) && (cy < 30);
            tick();
        end
        pulse_in = '0;
        rst_n    = 1'b0;
        tick();
        chk("mid_rst_level", level_out, 8'h00);
        chk("mid_rst_alarm", alarm, 1'b0);
        chk("mid_rst_wd", window_done, 1'b0);
        chk("mid_rst_count", count_out, 8'h00);
        rst_n = 1'b1;
        model_reset();
        run_window(0, 0, 0, 31, 1'b0, 0);

        repeat (3) tick();
        chk("sb_drain", sb_q.size(), 0);
        for (int t = 0; t < 2000 && !sat_finished; t++) tick();
        chk("sat_done", sat_finished, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
